// File: rtl/exp_engine_pkg.sv
// Shared definitions for the fixed-point exponential engine: FSM encoding,
// Q-format constants and the reciprocal generator used to fill the ROM.
package exp_engine_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULX = 3'd1,
    MULC = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Default fractional width and the matching Q2.F constant for 1.0.
  localparam int              DEF_F    = 16;
  localparam longint unsigned ONE      = 64'd1 << DEF_F;
  // Integer bits of the term/accumulator format (values stay below 4.0).
  localparam int              INT_BITS = 2;

  // floor(2^f / i); only ever evaluated at elaboration time.
  function automatic longint unsigned recip_val(input int f, input int i);
    return (longint'(1) << f) / longint'(i);
  endfunction

endpackage

// File: rtl/recip_rom.sv
// Constant reciprocal table: recip[i] = floor(2^F / i) for i = 1..TERMS-1,
// F+1 bits wide so that recip[1] = 2^F is representable.
module recip_rom
  import exp_engine_pkg::*;
#(
  parameter int F     = 16,
  parameter int TERMS = 8
) (
  input  logic [3:0] idx_i,
  output logic [F:0] recip_o
);

  logic [F:0] rom [16];

  // Fill the table with elaboration-time constants; unused slots read zero.
  for (genvar i = 0; i < 16; i++) begin : g_rom
    if (i >= 1 && i < TERMS) begin : g_val
      assign rom[i] = (F+1)'(recip_val(F, i));
    end else begin : g_zero
      assign rom[i] = '0;
    end
  end

  // NOTE: the table is pure constants, so it has no reset and no storage.
  always_comb recip_o = rom[idx_i];

endmodule

// File: rtl/exp_engine.sv
// Iterative e^x engine: truncated Taylor series, one multiply per cycle
// through a single shared multiplier, accumulated in Q2.F.
module exp_engine
  import exp_engine_pkg::*;
#(
  parameter int F     = 16,
  parameter int TERMS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         eng_start,
  input  logic [F-1:0] x_in,
  output logic         eng_done,
  output logic [F+1:0] result,
  output logic         busy
);

  localparam int             PW       = 2*F + INT_BITS + 1;
  localparam logic [F+1:0]   ONE_Q    = (F+2)'(1) << F;
  localparam logic [3:0]     LAST_IDX = 4'(TERMS-1);

  state_e         state_q, state_d;
  logic [F-1:0]   x_q, x_d;
  logic [F+1:0]   term_q, term_d;
  logic [F+1:0]   acc_q, acc_d;
  logic [3:0]     idx_q, idx_d;

  logic [F:0]     recip;
  logic [F:0]     mul_b;
  logic [PW-1:0]  prod;

  recip_rom #(
    .F    (F),
    .TERMS(TERMS)
  ) u_recip_rom (
    .idx_i  (idx_q),
    .recip_o(recip)
  );

  // Second multiplier operand: 1/idx while dividing, otherwise the operand x.
  always_comb mul_b = (state_q == MULC) ? recip : {1'b0, x_q};

  // Full-width product; the term update takes it >> F (truncation).
  assign prod = PW'(term_q) * PW'(mul_b);

  // Next-state and datapath update for the series iteration.
  always_comb begin
    // NOTE: every target gets a hold-value default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    x_d     = x_q;
    term_d  = term_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (eng_start) begin
          x_d     = x_in;
          term_d  = ONE_Q;
          acc_d   = ONE_Q;
          idx_d   = 4'd1;
          state_d = MULX;
        end
      end
      MULX: begin
        term_d  = (F+2)'(prod >> F);
        state_d = MULC;
      end
      MULC: begin
        term_d  = (F+2)'(prod >> F);
        state_d = ACC;
      end
      ACC: begin
        acc_d = acc_q + term_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = MULX;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  assign result   = acc_q;
  assign eng_done = (state_q == DONE);
  assign busy     = (state_q != IDLE);

endmodule
